// File: rtl/macc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// macc_ctrl_pkg
//   Shared definitions for the macc command sequencer: macc op_code values,
//   the controller state encoding and the per-term op_code selection rule.
// -----------------------------------------------------------------------------
package macc_ctrl_pkg;

  // macc op_code values: bit 2 = add op_add, bit 1 = accumulate, bit 0 = square
  localparam logic [2:0] OP_MUL     = 3'b000;
  localparam logic [2:0] OP_SQR     = 3'b001;
  localparam logic [2:0] OP_MUL_ACC = 3'b010;
  localparam logic [2:0] OP_SQR_ACC = 3'b011;
  localparam logic [2:0] OP_MUL_ADD = 3'b100;
  localparam logic [2:0] OP_SQR_ADD = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // The first term restarts the accumulator (optionally seeded with the bias);
  // every later term accumulates onto it.
  function automatic logic [2:0] term_op_code(input logic first,
                                              input logic bias_en,
                                              input logic square);
    if (first) return bias_en ? (square ? OP_SQR_ADD : OP_MUL_ADD)
                              : (square ? OP_SQR     : OP_MUL);
    return square ? OP_SQR_ACC : OP_MUL_ACC;
  endfunction

endpackage

// File: rtl/macc_ctrl.sv
// -----------------------------------------------------------------------------
// macc_ctrl
//   Sequencer in front of the macc primitive. Accepts one dot-product command,
//   streams its operand pairs into the macc back-to-back, waits out the macc
//   pipeline and presents the final result on a one-entry valid/ready slot.
//
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_len/square/bias_en/bias  command fields (cmd_len = 0 issues one 0*0 term)
//   in_valid/in_ready            operand pair handshake
//   in_op_0/in_op_1              operand pair
//   macc_enable..macc_op_add     registered drive of the macc inputs
//   macc_clear                   tied low
//   macc_out                     macc result
//   out_valid/out_ready/out_data result slot
//   busy                         high whenever a command is in progress
// -----------------------------------------------------------------------------
module macc_ctrl
  import macc_ctrl_pkg::*;
#(
  parameter int OP_WIDTH     = 16,
  parameter int ACC_WIDTH    = 48,
  parameter int OUT_WIDTH    = 16,
  parameter int LEN_WIDTH    = 10,
  parameter int MACC_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_square,
  input  logic                 cmd_bias_en,
  input  logic [ACC_WIDTH-1:0] cmd_bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op_0,
  input  logic [OP_WIDTH-1:0]  in_op_1,
  output logic                 macc_enable,
  output logic                 macc_clear,
  output logic [2:0]           macc_op_code,
  output logic [OP_WIDTH-1:0]  macc_op_0,
  output logic [OP_WIDTH-1:0]  macc_op_1,
  output logic [ACC_WIDTH-1:0] macc_op_add,
  input  logic [OUT_WIDTH-1:0] macc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
);

  localparam int DRAIN_WIDTH = (MACC_LATENCY < 2) ? 1 : $clog2(MACC_LATENCY + 1);

  state_e                 state;
  logic                   len_zero;
  logic                   square;
  logic                   bias_en;
  logic [ACC_WIDTH-1:0]   bias;
  logic [LEN_WIDTH-1:0]   remaining;
  logic                   first;
  logic [DRAIN_WIDTH-1:0] drain_cnt;

  // A zero-length command issues its single term without consuming an operand.
  assign in_ready   = (state == ISSUE) && !len_zero && (remaining != '0);
  assign busy       = (state != IDLE);
  assign macc_clear = 1'b0;

  // NOTE: every register here is assigned with <= so all right-hand sides see
  // the pre-edge values; blocking assignments would make later statements read
  // the already-updated state and silently change the schedule.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      len_zero     <= 1'b0;
      square       <= 1'b0;
      bias_en      <= 1'b0;
      bias         <= '0;
      remaining    <= '0;
      first        <= 1'b0;
      drain_cnt    <= '0;
      macc_enable  <= 1'b0;
      macc_op_code <= OP_MUL;
      macc_op_0    <= '0;
      macc_op_1    <= '0;
      macc_op_add  <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
    end else begin
      // macc_enable is a one-cycle pulse per issued term; op_code and the
      // operands simply hold through stalls.
      macc_enable <= 1'b0;

      // Consumption of the result slot; a capture below in the same cycle
      // overrides this and refills the slot.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            len_zero  <= (cmd_len == '0);
            square    <= cmd_square;
            bias_en   <= cmd_bias_en;
            bias      <= cmd_bias;
            remaining <= (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
            first     <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= ISSUE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ISSUE: begin
          if (remaining == '0) begin
            // Last term went out on the previous edge; now count the macc
            // pipeline down before its output can be trusted.
            drain_cnt <= DRAIN_WIDTH'(MACC_LATENCY);
            state     <= DRAIN;
          end else if (len_zero || in_valid) begin
            macc_enable  <= 1'b1;
            macc_op_code <= term_op_code(first, bias_en, square);
            macc_op_0    <= len_zero ? '0 : in_op_0;
            macc_op_1    <= len_zero ? '0 : in_op_1;
            macc_op_add  <= first ? bias : '0;
            first        <= 1'b0;
            remaining    <= remaining - LEN_WIDTH'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DRAIN_WIDTH'(1);
          end else if (!out_valid || out_ready) begin
            out_data  <= macc_out;
            out_valid <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/macc_ctrl.md
Name: macc_ctrl

Overview:
- Upstream sequencer for the macc primitive: one dot-product command in, one result out.
- Takes a command (term count, square mode, optional bias) and a stream of operand pairs over valid/ready.
- Drives macc enable/op_code/op_0/op_1/op_add so each command's terms accumulate back-to-back.
- Tracks the macc pipeline latency, captures the finished result and presents it on a valid/ready output.

Parameters:
- OP_WIDTH, 16, width of op_0/op_1 and macc op ports.
- ACC_WIDTH, 48, width of bias/op_add (macc accumulator width).
- OUT_WIDTH, 16, width of macc out and out_data.
- LEN_WIDTH, 10, width of cmd_len.
- MACC_LATENCY, 3, clock edges from an enabled macc input to the updated macc out.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when both high
- cmd_len  in  LEN_WIDTH  number of terms; 0 allowed
- cmd_square  in  1  1 = square mode (op_1 ignored)
- cmd_bias_en  in  1  1 = seed the accumulation with cmd_bias
- cmd_bias  in  ACC_WIDTH  bias value, unshifted integer format as macc op_add
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when both high
- in_op_0  in  OP_WIDTH  operand 0
- in_op_1  in  OP_WIDTH  operand 1
- macc_enable  out  1  to macc enable
- macc_clear  out  1  to macc clear; tied 0
- macc_op_code  out  3  to macc op_code
- macc_op_0  out  OP_WIDTH  to macc op_0
- macc_op_1  out  OP_WIDTH  to macc op_1
- macc_op_add  out  ACC_WIDTH  to macc op_add
- macc_out  in  OUT_WIDTH  from macc out
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when both high
- out_data  out  OUT_WIDTH  captured result
- busy  out  1  high in any state but IDLE

Behaviour:
- Reset (async, low):
  - State IDLE.
  - All outputs 0, except cmd_ready = 1 once reset is released.
  - Counters and the output register are cleared.
- Reset mid-command: in-flight terms are abandoned and no result is produced.
- Command and macc outputs: all registered; macc outputs are combinationally from flops.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch len, square, bias_en and bias, then go to ISSUE.
  - Set remaining = max(cmd_len, 1) and first = 1.
- ISSUE, operand transfer:
  - in_ready = 1 when cmd_len != 0.
  - Each transfer drives macc_enable = 1 on the next cycle with macc_op_0/1 = in_op_0/1.
  - op_code on the first term: {bias_en, 0, square}, i.e. 000/001 or 100/101.
  - op_code on later terms: {0, 1, square}, i.e. 010/011.
  - macc_op_add = bias on the first term, else 0.
  - remaining decrements by 1 per term.
- ISSUE, stalls: cycles without a transfer drive macc_enable = 0 and hold macc_op_code. The macc output holds across gaps.
- ISSUE, cmd_len = 0:
  - Issue exactly one term with operands 0 and in_ready held 0.
  - Result is bias (bias_en) or 0.
- ISSUE exit: on the last term, go to DRAIN with drain_cnt = MACC_LATENCY.
- DRAIN:
  - drain_cnt decrements each cycle.
  - At 0, macc_out holds the final value. If out_valid = 0 or (out_valid & out_ready), capture it into out_data, set out_valid and go to IDLE.
  - Otherwise wait in DRAIN. The macc output is stable because macc_enable = 0.
- Latency: last operand transfer at edge T → out_valid high after edge T + 1 + MACC_LATENCY + 1.
- Output: out_valid stays high and out_data stays stable until out_ready.
  - A new command may be accepted while the previous result waits.
  - A second result blocks in DRAIN until the slot frees.
  - Simultaneous consume and capture are allowed in the same cycle.
- Arithmetic:
  - Wrap and overflow semantics belong to macc; this block performs no arithmetic besides counters.
  - remaining is LEN_WIDTH bits and never underflows.

Decomposition:
- Shared package:
  - op_code constants: MUL=000, SQR=001, MUL_ACC=010, SQR_ACC=011, MUL_ADD=100, SQR_ADD=101.
  - State encoding IDLE/ISSUE/DRAIN.
- No sub-module; the output slot is a single register inside the block.

Test Plan:
- Drive cmd_len=3, square=0, bias_en=0 with pairs (2,3),(4,5),(1,1) into a real macc (FRAC_BITS=0) → op_codes 000,010,010; out_data=27; out_valid exactly 1+MACC_LATENCY+1 edges after the last transfer.
- Drive cmd_len=2, square=1, bias_en=1, bias=10 with op_0 = 3 then 4 → op_codes 101,011; out_data=35.
- Repeat the first case with in_valid toggling 1,0,0,1,0,1 → macc_enable follows the gaps; result still 27.
- Drive cmd_len=0 once with bias_en=1, bias=7 and once with bias_en=0 → in_ready never asserts; out_data 7 then 0.
- Hold out_ready=0 and run two back-to-back commands (results 27 and 35) → the first result stays stable, the second waits in DRAIN with busy=1; releasing out_ready delivers 27 then 35 in order.
- Assert reset low mid-ISSUE after 1 of 3 terms → outputs go 0 immediately, state IDLE, no out_valid; the next command gives a correct result.
